game_fsm_2048: RTL and testbench

Parametrised top-level control state machine for the 2048 game. It conditions N raw direction buttons, sequences the board datapath through initial spawn, move, spawn, and win/lose check, and exposes an encoded state for the display. It replaces the fixed 3-bit current/next-state pair with a handshaked controller that ignores input while the board is busy. It sits between the button pins and the board datapath.

---
 rtl/game_2048_pkg.sv | 31 +++
 rtl/game_fsm_2048_if.sv | 30 +++
 rtl/game_fsm_2048_button_conditioner.sv | 62 ++++++
 rtl/game_fsm_2048.sv | 171 +++++++++++++++++
 tb/tb_game_fsm_2048.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 game controller.
// State encoding is visible on the display port, so the values are fixed.
// Default parameter values live here so the top and sub-modules agree.
package game_2048_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_MOVE  = 3'd2,
    S_SPAWN = 3'd3,
    S_CHECK = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int DEF_N_DIRS          = 4;
  localparam int DEF_INIT_TILES      = 2;
  localparam int DEF_MOVE_CNT_W      = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // Width of a direction index for n buttons (never below one bit).
  function automatic int dir_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_fsm_2048_if.sv
// Request/done handshake between the game controller and the board datapath.
// The controller (master) pulses one request at a time and waits for board_done;
// result flags are only meaningful in the cycle board_done is high.
interface game_fsm_2048_if #(
  parameter int N_DIRS = 4
);
  import game_2048_pkg::*;

  localparam int DIR_W = dir_w(N_DIRS);

  logic             move_req;
  logic [DIR_W-1:0] move_dir;
  logic             spawn_req;
  logic             check_req;
  logic             board_done;
  logic             board_changed;
  logic             win_flag;
  logic             no_moves;

  modport master (
    output move_req, move_dir, spawn_req, check_req,
    input  board_done, board_changed, win_flag, no_moves
  );

  modport slave (
    input  move_req, move_dir, spawn_req, check_req,
    output board_done, board_changed, win_flag, no_moves
  );

endinterface

// File: rtl/game_fsm_2048_button_conditioner.sv
// Per-button conditioner: 2-FF synchronizer, optional debounce, rising-edge detect.
// Latency: press pulses 2 cycles after the raw level is captured (+DEBOUNCE_CYCLES
// with GAME_FSM_DEBOUNCE_EN). No backpressure: a held button yields one pulse.
module button_conditioner
  import game_2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic sync1, sync2, level, prev;

  // two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef GAME_FSM_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             level_q;

  // level follows the synchronized input only after it disagreed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (sync2 == level_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_q <= sync2;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = level_q;
`else
  assign level = sync2;
`endif

  // previous conditioned level, so only the rising edge produces an event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/game_fsm_2048.sv
// 2048 game controller: conditions buttons, sequences init spawns, move, spawn, check.
// Latency: button level to move_req is 3 edges (plus debounce); all outputs registered.
// Backpressure: one outstanding request, held until board_done; presses outside S_IDLE dropped.
// Optional feature macro: GAME_FSM_DEBOUNCE_EN (per-button debounce counters).
module game_fsm_2048
  import game_2048_pkg::*;
#(
  parameter int N_DIRS          = DEF_N_DIRS,
  parameter int INIT_TILES      = DEF_INIT_TILES,
  parameter int MOVE_CNT_W      = DEF_MOVE_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIRS-1:0]     buttons,
  game_fsm_2048_if.master       bus,
  output logic [2:0]            state,
  output logic                  win,
  output logic                  lose,
  output logic [MOVE_CNT_W-1:0] move_count
);

  localparam int DIR_W  = dir_w(N_DIRS);
  localparam int INIT_W = (INIT_TILES < 2) ? 1 : $clog2(INIT_TILES);

  logic [N_DIRS-1:0] press;
  logic              press_any;
  logic [DIR_W-1:0]  press_dir;

  for (genvar i = 0; i < N_DIRS; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst  (rst),
      .raw  (buttons[i]),
      .press(press[i])
    );
  end

  // lowest-index press wins when several arrive together
  always_comb begin
    press_any = 1'b0;
    press_dir = '0;
    for (int i = N_DIRS - 1; i >= 0; i--) begin
      if (press[i]) begin
        press_any = 1'b1;
        press_dir = DIR_W'(i);
      end
    end
  end

  state_t                 state_q, state_nxt;
  logic                   move_req_q, move_req_nxt;
  logic                   spawn_req_q, spawn_req_nxt;
  logic                   check_req_q, check_req_nxt;
  logic [DIR_W-1:0]       dir_q, dir_nxt;
  logic                   win_q, win_nxt;
  logic                   lose_q, lose_nxt;
  logic [MOVE_CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [INIT_W-1:0]      init_cnt_q, init_cnt_nxt;
  logic                   issued_q, issued_nxt;

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      move_req_q  <= 1'b0;
      spawn_req_q <= 1'b0;
      check_req_q <= 1'b0;
      dir_q       <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      cnt_q       <= '0;
      init_cnt_q  <= '0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      move_req_q  <= move_req_nxt;
      spawn_req_q <= spawn_req_nxt;
      check_req_q <= check_req_nxt;
      dir_q       <= dir_nxt;
      win_q       <= win_nxt;
      lose_q      <= lose_nxt;
      cnt_q       <= cnt_nxt;
      init_cnt_q  <= init_cnt_nxt;
      issued_q    <= issued_nxt;
    end
  end

  // next state; a request pulse is scheduled on the transition into its state
  always_comb begin
    state_nxt     = state_q;
    move_req_nxt  = 1'b0;
    spawn_req_nxt = 1'b0;
    check_req_nxt = 1'b0;
    dir_nxt       = dir_q;
    win_nxt       = win_q;
    lose_nxt      = lose_q;
    cnt_nxt       = cnt_q;
    init_cnt_nxt  = init_cnt_q;
    issued_nxt    = issued_q;
    case (state_q)
      S_INIT: begin
        if (INIT_TILES == 0) begin
          state_nxt = S_IDLE;
        end else if (!issued_q) begin
          // first spawn right after reset release
          spawn_req_nxt = 1'b1;
          issued_nxt    = 1'b1;
        end else if (bus.board_done) begin
          if (init_cnt_q == INIT_W'(INIT_TILES - 1)) begin
            state_nxt = S_IDLE;
          end else begin
            init_cnt_nxt  = init_cnt_q + 1'b1;
            spawn_req_nxt = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (press_any) begin
          dir_nxt      = press_dir;
          move_req_nxt = 1'b1;
          state_nxt    = S_MOVE;
        end
      end
      S_MOVE: begin
        if (bus.board_done) begin
          if (bus.board_changed) begin
            spawn_req_nxt = 1'b1;
            state_nxt     = S_SPAWN;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_SPAWN: begin
        if (bus.board_done) begin
          check_req_nxt = 1'b1;
          state_nxt     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.board_done) begin
          if (cnt_q != '1) cnt_nxt = cnt_q + 1'b1;
          if (bus.win_flag) begin
            win_nxt   = 1'b1;
            state_nxt = S_WIN;
          end else if (bus.no_moves) begin
            lose_nxt  = 1'b1;
            state_nxt = S_LOSE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_WIN, S_LOSE: state_nxt = state_q;
      default:       state_nxt = S_INIT;
    endcase
  end

  assign bus.move_req  = move_req_q;
  assign bus.move_dir  = dir_q;
  assign bus.spawn_req = spawn_req_q;
  assign bus.check_req = check_req_q;
  assign state         = state_q;
  assign win           = win_q;
  assign lose          = lose_q;
  assign move_count    = cnt_q;

endmodule

// File: tb/tb_game_fsm_2048.sv
// Scoreboard bench for game_fsm_2048: stimulus pushes expected request sequences,
// a negedge monitor pops and compares each request pulse the DUT emits,
// and a datapath responder answers requests with configurable latency.
module tb_game_fsm_2048;
  import game_2048_pkg::*;

  localparam int N          = 4;
  localparam int INIT_TILES = 2;
  localparam int CW         = 16;
  localparam int DEB        = 16;
`ifdef GAME_FSM_DEBOUNCE_EN
  localparam int SETTLE = DEB + 6;
`else
  localparam int SETTLE = 5;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  buttons;
  logic [2:0]    state;
  logic          win, lose;
  logic [CW-1:0] move_count;

  game_fsm_2048_if #(.N_DIRS(N)) bif();

  game_fsm_2048 #(
    .N_DIRS(N), .INIT_TILES(INIT_TILES), .MOVE_CNT_W(CW), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .bus(bif),
    .state(state), .win(win), .lose(lose), .move_count(move_count)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int dir; } exp_t;   // kind: 0 move, 1 spawn, 2 check
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // expected game-level model
  logic [CW-1:0] exp_cnt;
  logic          exp_win, exp_lose;

  // datapath responder configuration
  int cfg_lat = 1;     // negative: random 0..3
  bit cfg_changed = 0, cfg_win = 0, cfg_nomv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(input int k, input int d);
    exp_t e;
    e.kind = k;
    e.dir  = d;
    exp_q.push_back(e);
  endfunction

  // monitor: every request pulse must match the head of the expectation queue
  int   mon_n, mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b0 && (bif.move_req || bif.spawn_req || bif.check_req)) begin
      mon_n = int'(bif.move_req) + int'(bif.spawn_req) + int'(bif.check_req);
      if (mon_n != 1) check("req_onehot", mon_n, 1);
      mon_kind = bif.move_req ? 0 : (bif.spawn_req ? 1 : 2);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_req: got request kind %0d dir %0d, required none (t=%0t)",
                 mon_kind, bif.move_dir, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("req_kind", mon_kind, mon_e.kind);
        if (mon_kind == 0) check("req_move_dir", 32'(bif.move_dir), mon_e.dir);
      end
    end
  end

  // board datapath stand-in: answers each request after a latency
  initial begin
    int pend, l;
    pend = 0;
    bif.board_done = 1'b0;
    bif.board_changed = 1'b0;
    bif.win_flag = 1'b0;
    bif.no_moves = 1'b0;
    forever begin
      @(negedge clk);
      bif.board_changed = cfg_changed;
      bif.win_flag      = cfg_win;
      bif.no_moves      = cfg_nomv;
      bif.board_done    = 1'b0;
      if (rst !== 1'b0) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) bif.board_done = 1'b1;
        end
        if (bif.move_req || bif.spawn_req || bif.check_req) begin
          l = (cfg_lat < 0) ? int'($urandom_range(0, 3)) : cfg_lat;
          if (l == 0) bif.board_done = 1'b1;
          else        pend = l;
        end
      end
    end
  end

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout with %0d requests outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && state !== s; i++) @(negedge clk);
    check(name, 32'(state), 32'(s));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    buttons = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    exp_cnt  = '0;
    exp_win  = 1'b0;
    exp_lose = 1'b0;
    for (int i = 0; i < INIT_TILES; i++) push_exp(1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_spawn_req", 32'(bif.spawn_req), 1);
    wait_empty("init_spawns", 40);
    wait_state("init_to_idle", 3'd1, 40);
    check("init_move_count", 32'(move_count), 0);
  endtask

  // one player move: expected requests follow from the game rules
  task automatic do_move(input logic [N-1:0] mask, input bit changed, input bit win_f,
                         input bit nomv, input int lat, input int hold);
    int d;
    logic [2:0] fs;
    d = -1;
    for (int i = 0; i < N; i++) if (mask[i] && d < 0) d = i;
    push_exp(0, d);
    fs = 3'd1;
    if (changed) begin
      push_exp(1, 0);
      push_exp(2, 0);
      if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      if (win_f) begin
        fs = 3'd5;
        exp_win = 1'b1;
      end else if (nomv) begin
        fs = 3'd6;
        exp_lose = 1'b1;
      end
    end
    cfg_lat = lat;
    cfg_changed = changed;
    cfg_win = win_f;
    cfg_nomv = nomv;
    buttons = mask;
    wait_empty("move_reqs", 200);
    wait_state("move_final_state", fs, 60);
    check("move_count", 32'(move_count), 32'(exp_cnt));
    check("win_flag_out", 32'(win), 32'(exp_win));
    check("lose_flag_out", 32'(lose), 32'(exp_lose));
    check("move_dir_held", 32'(bif.move_dir), d);
    repeat (hold) @(negedge clk);
    buttons = '0;
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    buttons = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_move_req", 32'(bif.move_req), 0);
    check("rst_spawn_req", 32'(bif.spawn_req), 0);
    check("rst_check_req", 32'(bif.check_req), 0);
    check("rst_move_dir", 32'(bif.move_dir), 0);
    check("rst_win_lose", 32'({win, lose}), 0);
    check("rst_move_count", 32'(move_count), 0);

    cfg_lat = 1;
    do_reset();

    // directed moves
    do_move(4'b0100, 1, 0, 0, 1, 0);     // left, board changes
    do_move(4'b0001, 0, 0, 0, 1, 0);     // up, no change: no spawn, no count
    do_move(4'b1010, 1, 0, 0, 1, 50);    // down+right together, held 50 cycles

    // a new press while spawning is discarded
    push_exp(0, DIR_LEFT);
    push_exp(1, 0);
    push_exp(2, 0);
    exp_cnt = exp_cnt + 1'b1;
    cfg_lat = 6;
    cfg_changed = 1;
    buttons = 4'b0100;
    wait_state("reach_spawn", 3'd3, 100);
    buttons = 4'b1100;
    wait_empty("spawn_press_reqs", 100);
    wait_state("spawn_press_idle", 3'd1, 60);
    repeat (10) @(negedge clk);
    check("spawn_press_count", 32'(move_count), 32'(exp_cnt));
    buttons = '0;
    repeat (SETTLE) @(negedge clk);

    // randomized moves that keep the game running
    for (int it = 0; it < 25; it++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      do_move(m, 1'($urandom_range(0, 1)), 0, 0, -1, int'($urandom_range(0, 5)));
    end

    // win takes priority over no_moves; terminal state ignores presses
    do_move(4'b0010, 1, 1, 1, -1, 0);
    buttons = 4'b0001;
    repeat (20) @(negedge clk);
    buttons = '0;
    repeat (SETTLE) @(negedge clk);
    buttons = 4'b1000;
    repeat (20) @(negedge clk);
    buttons = '0;
    check("win_terminal_state", 32'(state), 5);
    check("win_terminal_flags", 32'({win, lose}), 32'b10);

    // asynchronous reset while a move is outstanding
    cfg_lat = 1;
    do_reset();
    do_move(4'b0100, 1, 0, 0, 1, 0);
    push_exp(0, DIR_RIGHT);
    cfg_lat = 20;
    cfg_changed = 0;
    buttons = 4'b1000;
    wait_state("reach_move", 3'd2, 100);
    wait_empty("mid_move_req", 10);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_move_dir", 32'(bif.move_dir), 0);
    check("async_rst_reqs", 32'({bif.move_req, bif.spawn_req, bif.check_req}), 0);
    check("async_rst_count", 32'(move_count), 0);
    cfg_lat = 1;
    do_reset();

    // separate game ending in a loss
    do_move(4'b0001, 1, 0, 1, 1, 0);
    check("lose_state", 32'(state), 6);

`ifdef GAME_FSM_DEBOUNCE_EN
    // a short glitch never reaches the controller
    do_reset();
    buttons = 4'b0001;
    repeat (10) @(negedge clk);
    buttons = '0;
    repeat (3 * DEB) @(negedge clk);
    check("glitch_ignored_state", 32'(state), 1);
    do_move(4'b0010, 1, 0, 0, 1, 0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
